// File: rtl/uart_reg_responder.sv
// Purpose: decodes A5-framed register read/write commands from a UART byte stream and answers with a 2-byte reply.
// Latency: tx_valid is visible the cycle after the edge that samples the last frame byte.
// Backpressure: none on rx (bytes during a reply are dropped and counted); tx_ready low stalls the reply indefinitely.
module uart_reg_responder #(
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_tvalid,
    input  logic [7:0] rx_tdata,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_tdata,
    output logic [7:0] reg0,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SOF     = 8'hA5;
    localparam logic [7:0] RSP_HDR = 8'h5A;
    localparam logic [7:0] ACK     = 8'h00;
    localparam logic [7:0] NAK     = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        RESP_HDR,
        RESP_BODY
    } state_t;

    state_t          state, state_nxt;
    logic            is_write;
    logic [7:0]      addr_q;
    logic [7:0]      body_q;
    logic [7:0]      regs [DEPTH];
    logic [7:0]      err_q;
    logic [TW-1:0]   tmo_q;

    logic            cmd_ld;
    logic            addr_ld;
    logic            body_ld;
    logic [7:0]      body_nxt;
    logic            wr_en;
    logic            err_inc;
    logic            in_frame;
    logic            rx_addr_ok;
    logic            lat_addr_ok;

    // Addresses beyond the bank depth are rejected rather than aliased.
    assign rx_addr_ok  = (rx_tdata >> ADDR_WIDTH) == 8'd0;
    assign lat_addr_ok = (addr_q >> ADDR_WIDTH) == 8'd0;
    assign in_frame    = (state == CMD) || (state == ADDR) || (state == DATA);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Frame decode, reply selection and inter-byte timeout.
    always_comb begin
        state_nxt = state;
        cmd_ld    = 1'b0;
        addr_ld   = 1'b0;
        body_ld   = 1'b0;
        body_nxt  = ACK;
        wr_en     = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_tvalid && rx_tdata == SOF) state_nxt = CMD;
            end
            CMD: begin
                if (rx_tvalid) begin
                    if (rx_tdata == 8'h01 || rx_tdata == 8'h02) begin
                        cmd_ld    = 1'b1;
                        state_nxt = ADDR;
                    end else begin
                        body_ld   = 1'b1;
                        body_nxt  = NAK;
                        err_inc   = 1'b1;
                        state_nxt = RESP_HDR;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ADDR: begin
                if (rx_tvalid) begin
                    addr_ld = 1'b1;
                    if (is_write) begin
                        state_nxt = DATA;
                    end else begin
                        body_ld   = 1'b1;
                        state_nxt = RESP_HDR;
                        if (rx_addr_ok) begin
                            body_nxt = regs[rx_tdata[ADDR_WIDTH-1:0]];
                        end else begin
                            body_nxt = NAK;
                            err_inc  = 1'b1;
                        end
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (rx_tvalid) begin
                    body_ld   = 1'b1;
                    state_nxt = RESP_HDR;
                    if (lat_addr_ok) begin
                        wr_en = 1'b1;
                    end else begin
                        body_nxt = NAK;
                        err_inc  = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RESP_HDR: begin
                err_inc = rx_tvalid;
                if (tx_ready) state_nxt = RESP_BODY;
            end
            RESP_BODY: begin
                err_inc = rx_tvalid;
                if (tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame context, reply buffer, error counter and silence counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write <= 1'b0;
            addr_q   <= 8'h00;
            body_q   <= 8'h00;
            err_q    <= 8'h00;
            tmo_q    <= '0;
        end else begin
            if (cmd_ld)  is_write <= (rx_tdata == 8'h01);
            if (addr_ld) addr_q   <= rx_tdata;
            if (body_ld) body_q   <= body_nxt;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
            // Counts silent cycles while staying in the same frame state.
            if (in_frame && !rx_tvalid && state_nxt == state) tmo_q <= tmo_q + 1'b1;
            else                                              tmo_q <= '0;
        end
    end

    // Register bank; a write lands on the edge that samples the data byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else if (wr_en) begin
            regs[addr_q[ADDR_WIDTH-1:0]] <= rx_tdata;
        end
    end

    assign tx_valid = (state == RESP_HDR) || (state == RESP_BODY);
    assign tx_tdata = (state == RESP_HDR)  ? RSP_HDR :
                      (state == RESP_BODY) ? body_q  : 8'h00;
    assign reg0     = regs[0];
    assign busy     = (state != IDLE);
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Testbench for uart_reg_responder: random and directed frames against a frame-level register model.
// Expected reply bytes are queued at issue time and popped by an independent tx monitor.
// tx_ready is randomised while draining replies to exercise stalls.
module tb_uart_reg_responder;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_tvalid = 1'b0;
    logic [7:0] rx_tdata = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_valid;
    logic [7:0] tx_tdata;
    logic [7:0] reg0;
    logic       busy;
    logic [7:0] err_cnt;

    uart_reg_responder #(.ADDR_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_tdata(tx_tdata),
        .reg0(reg0), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_regs[16];
    int         m_err = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_err_sat();
        return (m_err > 255) ? 8'hFF : 8'(m_err);
    endfunction

    // Monitor: pops one expected byte per tx handshake, checks hold-during-stall.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_dat;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_dat   = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall) begin
                    chk("tx_hold_valid", 8'(tx_valid), 8'h01);
                    chk("tx_hold_data", tx_tdata, prev_dat);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: got %02h expected no byte", tx_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", tx_tdata, e);
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_dat   = tx_tdata;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        tick();
        rx_tvalid = 1'b0;
        rx_tdata  = 8'($urandom_range(0, 255));
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic push_reply(input logic [7:0] body);
        exp_q.push_back(8'h5A);
        exp_q.push_back(body);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            tx_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
            exp_q.delete();
        end
        tx_ready = 1'b1;
        tick();
    endtask

    // Issue one frame; the expected reply comes from the register model.
    task automatic do_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hA5);
        gap();
        if (c != 8'h01 && c != 8'h02) begin
            push_reply(8'hEE);
            m_err++;
            send_byte(c);
        end else begin
            send_byte(c);
            gap();
            if (c == 8'h02) begin
                if (a < 8'd16) push_reply(m_regs[a[3:0]]);
                else begin push_reply(8'hEE); m_err++; end
                send_byte(a);
            end else begin
                send_byte(a);
                gap();
                if (a < 8'd16) begin push_reply(8'h00); m_regs[a[3:0]] = d; end
                else begin push_reply(8'hEE); m_err++; end
                send_byte(d);
            end
        end
        wait_drain();
    endtask

    initial begin
        logic [7:0] c, a, d, b;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 8'(tx_valid), 8'h00);
        chk("rst_tx_tdata", tx_tdata, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_err_cnt", err_cnt, 8'h00);
        chk("rst_reg0", reg0, 8'h00);
        rst_n = 1'b1;
        tick();

        // Write then read back
        do_frame(8'h01, 8'h03, 8'hC7);
        do_frame(8'h02, 8'h03, 8'h00);
        chk("wr_rd_err_cnt", err_cnt, 8'h00);
        do_frame(8'h01, 8'h00, 8'h3C);
        chk("reg0_write", reg0, 8'h3C);

        // Protocol errors
        do_frame(8'h07, 8'h00, 8'h00);
        chk("bad_cmd_err_cnt", err_cnt, 8'h01);
        do_frame(8'h02, 8'h10, 8'h00);
        do_frame(8'h01, 8'h20, 8'h55);
        chk("bad_addr_err_cnt", err_cnt, 8'h03);
        chk("bad_addr_no_alias", reg0, 8'h3C);
        do_frame(8'h02, 8'h00, 8'h00);

        // Backpressure with a stray rx byte mid-reply
        tx_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h02);
        push_reply(m_regs[3]);
        send_byte(8'h03);
        for (int i = 0; i < 50; i++) begin
            if (i == 25) begin
                send_byte(8'h11);
                m_err++;
            end else begin
                tick();
            end
            chk("stall_valid", 8'(tx_valid), 8'h01);
            chk("stall_data", tx_tdata, 8'h5A);
        end
        wait_drain();
        chk("stall_drop_err_cnt", err_cnt, m_err_sat());

        // Timeout after 100 silent cycles: no reply, no write
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        repeat (TMO - 1) tick();
        chk("tmo_busy_before", 8'(busy), 8'h01);
        tick();
        m_err++;
        chk("tmo_busy_after", 8'(busy), 8'h00);
        chk("tmo_tx_valid", 8'(tx_valid), 8'h00);
        chk("tmo_err_cnt", err_cnt, m_err_sat());
        do_frame(8'h02, 8'h05, 8'h00);

        // Byte on the final silent cycle is accepted
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        repeat (TMO - 1) tick();
        push_reply(8'h00);
        m_regs[5] = 8'h77;
        send_byte(8'h77);
        wait_drain();
        do_frame(8'h02, 8'h05, 8'h00);
        chk("tmo_edge_err_cnt", err_cnt, m_err_sat());

        // Idle noise is ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        do_frame(8'h02, 8'h00, 8'h00);
        chk("noise_err_cnt", err_cnt, m_err_sat());

        // Randomised traffic
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                send_byte(b);
            end
            case ($urandom_range(0, 7))
                0, 1, 2: c = 8'h01;
                3, 4, 5: c = 8'h02;
                default: c = 8'($urandom_range(0, 255));
            endcase
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            do_frame(c, a, d);
        end
        chk("rand_err_cnt", err_cnt, m_err_sat());
        chk("rand_reg0", reg0, m_regs[0]);

        // Asynchronous reset during a stalled reply
        tx_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (3) tick();
        chk("pre_rst_tx_valid", 8'(tx_valid), 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 8'(tx_valid), 8'h00);
        chk("mid_rst_tx_tdata", tx_tdata, 8'h00);
        chk("mid_rst_busy", 8'(busy), 8'h00);
        chk("mid_rst_err_cnt", err_cnt, 8'h00);
        chk("mid_rst_reg0", reg0, 8'h00);
        exp_q.delete();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_err = 0;
        tick();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        tick();
        do_frame(8'h02, 8'h03, 8'h00);
        chk("post_rst_err_cnt", err_cnt, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
